// File: rtl/addsub_vector_checker.sv
// Exhaustive checker for a 4-bit adder-subtractor: sweeps all 512 {sel,A,B} vectors,
// waits SETTLE cycles per vector, compares {cout,S}. Define CHECK_OVERFLOW_EN to also check ovf.
module addsub_vector_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       sel,
    input  logic [3:0] S,
    input  logic       cout,
`ifdef CHECK_OVERFLOW_EN
    input  logic       ovf,
`endif
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [8:0] fail_vec
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StApply = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StCheck = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);
    localparam logic [8:0] LastVec    = 9'd511;

    logic [2:0] state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] err_q, err_d;
    logic [8:0] fail_q, fail_d;

    logic [4:0] exp_res;
    logic       mismatch;

    // The operands are the vector index itself, so they hold in WAIT/CHECK/IDLE/DONE for free.
    assign {sel, A, B} = idx_q;

    assign busy      = (state_q == StApply) || (state_q == StWait) || (state_q == StCheck);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_q == 8'd0);
    assign err_count = err_q;
    assign fail_vec  = fail_q;

    always_comb begin
        if (sel) begin
            exp_res = {1'b0, A} + {1'b0, ~B} + 5'd1;
        end else begin
            exp_res = {1'b0, A} + {1'b0, B};
        end
        mismatch = ({cout, S} != exp_res);
`ifdef CHECK_OVERFLOW_EN
        if (sel) begin
            mismatch = mismatch ||
                       (ovf != ((A[3] != B[3]) && (exp_res[3] != A[3])));
        end else begin
            mismatch = mismatch ||
                       (ovf != ((A[3] == B[3]) && (exp_res[3] != A[3])));
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StApply;
                    idx_d   = 9'd0;
                    err_d   = 8'd0;
                    fail_d  = 9'd0;
                end
            end
            StApply: begin
                state_d = StWait;
                cnt_d   = 4'd0;
            end
            StWait: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    // A zero count means this is the first mismatch of the sweep.
                    if (err_q == 8'd0) begin
                        fail_d = idx_q;
                    end
                end
                if (idx_q == LastVec) begin
                    state_d = StDone;
                end else begin
                    state_d = StApply;
                    idx_d   = idx_q + 9'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 9'd0;
            cnt_q   <= 4'd0;
            err_q   <= 8'd0;
            fail_q  <= 9'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

endmodule
